div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 Parameter: TAG_W, 5, width of destination/instruction tag carried with each divide.
REQ-002 Reset is resetn, synchronous, active-low; clock is div_clk.
REQ-003 Ports, name  direction  width  meaning:
- div_clk  in  1  clock
- resetn  in  1  sync active-low reset
- req_valid  in  1  EX stage presents DIV/DIVU
- req_ready  out  1  controller accepts request this cycle
- req_signed  in  1  1=DIV, 0=DIVU
- req_x  in  32  dividend
- req_y  in  32  divisor
- req_tag  in  TAG_W  tag
- flush  in  1  pipeline cancel
- dv_div  out  1  start pulse to divider
- dv_signed  out  1  signed select to divider
- dv_x  out  32  divider dividend
- dv_y  out  32  divider divisor
- dv_s  in  32  divider quotient
- dv_r  in  32  divider remainder
- dv_complete  in  1  divider done, one-cycle pulse
- res_valid  out  1  result available
- res_ready  in  1  consumer (HI/LO writeback) takes result
- res_lo  out  32  quotient
- res_hi  out  32  remainder
- res_tag  out  TAG_W  tag of result
- res_dz  out  1  result came from zero divisor
- busy  out  1  divide in flight (pipeline stall)

Function
REQ-004 FSM states IDLE, RUN, DONE, DRAIN; exactly one active.
REQ-005 req_ready SHALL be 1 only in IDLE with flush=0; accept = req_valid & req_ready.
REQ-006 On accept with req_y!=0: register dv_x=req_x, dv_y=req_y, dv_signed=req_signed, tag; set dv_div=1 for exactly one cycle (the cycle after the accept edge); go RUN.
REQ-007 dv_div SHALL never be high outside the single launch cycle; dv_x/dv_y/dv_signed SHALL stay stable from launch until the capturing dv_complete edge.
REQ-008 On accept with req_y==0: no divider launch; go directly to DONE with res_lo=32'hFFFF_FFFF, res_hi=req_x, res_dz=1, res_valid=1 the next cycle.
REQ-009 RUN: on edge where dv_complete=1, capture res_lo=dv_s, res_hi=dv_r, res_dz=0, go DONE; res_valid=1 the following cycle.
REQ-010 Latency with divider: dv_complete at 33 edges after accept edge; res_valid high after the 34th edge.
REQ-011 DONE: res_valid=1, res_lo/res_hi/res_tag/res_dz held stable until res_valid & res_ready; then IDLE (next accept possible the cycle after).
REQ-012 busy SHALL be 1 in RUN, DRAIN, DONE; 0 in IDLE.
REQ-013 flush in IDLE: no accept that cycle, even if req_valid=1.
REQ-014 flush in RUN: go DRAIN; divider is not aborted.
REQ-015 DRAIN: wait for dv_complete, discard result, return to IDLE; res_valid stays 0; req_ready stays 0.
REQ-016 flush in DONE: drop result, res_valid=0 next cycle, go IDLE; flush takes priority over res_ready in the same cycle.
REQ-017 dv_complete in IDLE or DONE SHALL be ignored (no state or output change).
REQ-018 flush in DRAIN has no further effect; dv_complete and flush in the same RUN cycle: go IDLE, no result.

Reset
REQ-019 On a div_clk edge with resetn=0: state=IDLE; dv_div, dv_signed, res_valid, res_dz, busy = 0; dv_x, dv_y, res_lo, res_hi, res_tag = 0; req_ready=1 from the first cycle after reset.
REQ-020 Reset mid-RUN/DRAIN SHALL return to IDLE immediately; the divider shares resetn, so there is no stale completion.

Verification
REQ-021 Unsigned: req x=100, y=7, signed=0 -> one dv_div pulse; res_valid after 34 edges; lo=14, hi=2, res_dz=0.
REQ-022 Signed: x=-7 (32'hFFFF_FFF9), y=2, signed=1 -> lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1).
REQ-023 Zero divisor: x=5, y=0 -> no dv_div; res_valid the next cycle; lo=32'hFFFF_FFFF, hi=5, res_dz=1.
REQ-024 Backpressure: hold res_ready=0 for 10 cycles after res_valid -> outputs stable, req_ready=0, busy=1; res_ready=1 -> IDLE next cycle.
REQ-025 Flush at cycle 10 of RUN -> DRAIN; dv_complete consumed without res_valid; new request accepted the cycle after DRAIN exits and yields the correct result.
REQ-026 resetn=0 for one edge mid-RUN -> all outputs at reset values, req_ready=1 next cycle, no res_valid from the aborted divide.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: request, divider and result bundle of the divide issue controller
interface div_issue_ctrl_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [31:0]      req_x;
  logic [31:0]      req_y;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             dv_div;
  logic             dv_signed;
  logic [31:0]      dv_x;
  logic [31:0]      dv_y;
  logic [31:0]      dv_s;
  logic [31:0]      dv_r;
  logic             dv_complete;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_lo;
  logic [31:0]      res_hi;
  logic [TAG_W-1:0] res_tag;
  logic             res_dz;
  logic             busy;
  modport master (
    output req_valid, req_signed, req_x, req_y, req_tag, flush, dv_s, dv_r, dv_complete, res_ready,
    input  req_ready, dv_div, dv_signed, dv_x, dv_y, res_valid, res_lo, res_hi, res_tag, res_dz, busy
  );
  modport slave (
    input  req_valid, req_signed, req_x, req_y, req_tag, flush, dv_s, dv_r, dv_complete, res_ready,
    output req_ready, dv_div, dv_signed, dv_x, dv_y, res_valid, res_lo, res_hi, res_tag, res_dz, busy
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: launches one divide at a time, holds its result for writeback, handles flush
module div_issue_ctrl #(parameter int TAG_W = 5) (
  input logic              div_clk,
  input logic              resetn,
  div_issue_ctrl_if.slave  dbus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, DRAIN = 2'd3;
  logic [1:0]       r_state;
  logic             r_dv_div, r_dv_signed, r_res_dz;
  logic [31:0]      r_dv_x, r_dv_y, r_res_lo, r_res_hi;
  logic [TAG_W-1:0] r_tag;
  logic             w_accept, w_zero;
  assign dbus.req_ready = r_state == IDLE && !dbus.flush;
  assign w_accept       = dbus.req_valid && dbus.req_ready;
  assign w_zero         = dbus.req_y == 32'd0;
  assign dbus.dv_div    = r_dv_div;
  assign dbus.dv_signed = r_dv_signed;
  assign dbus.dv_x      = r_dv_x;
  assign dbus.dv_y      = r_dv_y;
  assign dbus.res_valid = r_state == DONE;
  assign dbus.res_lo    = r_res_lo;
  assign dbus.res_hi    = r_res_hi;
  assign dbus.res_tag   = r_tag;
  assign dbus.res_dz    = r_res_dz;
  assign dbus.busy      = r_state != IDLE;
  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_dv_div    <= 1'b0;
      r_dv_signed <= 1'b0;
      r_dv_x      <= '0;
      r_dv_y      <= '0;
      r_res_lo    <= '0;
      r_res_hi    <= '0;
      r_res_dz    <= 1'b0;
      r_tag       <= '0;
    end else begin
      r_dv_div <= w_accept && !w_zero;
      case (r_state)
        IDLE: if (w_accept) begin
          r_tag <= dbus.req_tag;
          if (w_zero) begin
            r_res_lo <= '1;
            r_res_hi <= dbus.req_x;
            r_res_dz <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_dv_x      <= dbus.req_x;
            r_dv_y      <= dbus.req_y;
            r_dv_signed <= dbus.req_signed;
            r_state     <= RUN;
          end
        end
        RUN: if (dbus.dv_complete) begin
          r_state <= dbus.flush ? IDLE : DONE;
          if (!dbus.flush) begin
            r_res_lo <= dbus.dv_s;
            r_res_hi <= dbus.dv_r;
            r_res_dz <= 1'b0;
          end
        end else if (dbus.flush) r_state <= DRAIN;
        DONE: if (dbus.flush || dbus.res_ready) r_state <= IDLE;
        default: if (dbus.dv_complete) r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed vectors with a result scoreboard and a 33-cycle divider model
module tb_div_issue_ctrl;
  logic div_clk = 1'b0;
  logic resetn  = 1'b0;
  always #5 div_clk = ~div_clk;
  div_issue_ctrl_if #(.TAG_W(5)) bus ();
  div_issue_ctrl #(.TAG_W(5)) dut (.div_clk(div_clk), .resetn(resetn), .dbus(bus));
  typedef struct packed {logic [31:0] lo; logic [31:0] hi; logic [4:0] tag; logic dz;} res_t;
  typedef struct {logic [31:0] x; logic [31:0] y; logic s; logic [4:0] tag; logic [31:0] lo; logic [31:0] hi; logic dz; int lat; int hold;} vec_t;
  res_t sb[$];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic inj = 1'b0;
  logic mcomp, dact, dstable, ls;
  logic [5:0] dcnt;
  logic [31:0] ds, dr, lx, ly;
  assign bus.dv_complete = mcomp | inj;
  assign bus.dv_s = ds;
  assign bus.dv_r = dr;
  // divider model: samples operands at the start pulse, completes 32 edges later
  always @(posedge div_clk) begin
    if (!resetn) begin
      dact <= 1'b0; mcomp <= 1'b0; dcnt <= '0; dstable <= 1'b1;
    end else begin
      mcomp <= 1'b0;
      if (bus.dv_div) begin
        dact <= 1'b1; dcnt <= 6'd1; dstable <= 1'b1;
        lx <= bus.dv_x; ly <= bus.dv_y; ls <= bus.dv_signed;
      end else if (dact) begin
        dcnt <= dcnt + 6'd1;
        if (bus.dv_x != lx || bus.dv_y != ly || bus.dv_signed != ls) dstable <= 1'b0;
        if (dcnt == 6'd32) begin
          dact <= 1'b0; mcomp <= 1'b1;
          if (ls) begin
            ds <= 32'($signed(lx) / $signed(ly));
            dr <= 32'($signed(lx) % $signed(ly));
          end else begin
            ds <= lx / ly;
            dr <= lx % ly;
          end
        end
      end
    end
  end
  res_t cur, prv, e;
  logic pv = 1'b0;
  always @(negedge div_clk) begin
    cur = {bus.res_lo, bus.res_hi, bus.res_tag, bus.res_dz};
    if (bus.dv_div) pulses++;
    if (bus.res_valid && pv) begin
      checks++;
      if (cur !== prv) begin errors++; $display("FAIL res_hold got %h want %h", cur, prv); end
    end
    if (bus.res_valid && bus.res_ready && !bus.flush) begin
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL unexpected_result got %h want none", cur); end
      else begin
        e = sb.pop_front();
        if (cur !== e) begin errors++; $display("FAIL result got %h want %h", cur, e); end
      end
    end
    if (mcomp) begin
      checks++;
      if (!dstable) begin errors++; $display("FAIL dv_operands_stable got 0 want 1"); end
    end
    pv = bus.res_valid && !bus.res_ready && !bus.flush && resetn;
    prv = cur;
  end
  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %h want %h", nm, act, exp); end
  endtask
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input logic [4:0] tag, output int w);
    w = 0;
    while (!bus.req_ready && w < 200) begin tick(); w++; end
    bus.req_valid = 1'b1; bus.req_x = x; bus.req_y = y; bus.req_signed = s; bus.req_tag = tag;
    tick();
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.res_valid && n < 60) begin tick(); n++; end
  endtask
  task automatic run_vec(input vec_t v);
    int w, n, p0;
    p0 = pulses;
    sb.push_back({v.lo, v.hi, v.tag, v.dz});
    issue(v.x, v.y, v.s, v.tag, w);
    chk("ready_wait", 32'(w), 32'd0);
    wait_valid(n);
    chk("latency", 32'(n), 32'(v.lat));
    for (int i = 0; i < v.hold; i++) tick();
    if (v.hold > 0) begin
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("dv_pulses", 32'(pulses - p0), v.dz ? 32'd0 : 32'd1);
  endtask
  vec_t vecs[5];
  initial begin
    int w, n, p0;
    vecs[0] = '{32'd100, 32'd7, 1'b0, 5'd1, 32'd14, 32'd2, 1'b0, 34, 0};
    vecs[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 5'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0};
    vecs[2] = '{32'd5, 32'd0, 1'b0, 5'd3, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0};
    vecs[3] = '{32'hFFFF_FFF9, 32'd2, 1'b0, 5'd4, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, 10};
    vecs[4] = '{32'd1000, 32'd10, 1'b1, 5'd31, 32'd100, 32'd0, 1'b0, 34, 0};
    bus.req_valid = 1'b0; bus.req_signed = 1'b0; bus.req_x = '0; bus.req_y = '0; bus.req_tag = '0;
    bus.flush = 1'b0; bus.res_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_dv_div", 32'(bus.dv_div), 32'd0);
    chk("rst_res_lo", bus.res_lo, 32'd0);
    chk("rst_dv_x", bus.dv_x, 32'd0);
    resetn = 1'b1;
    #1 chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    foreach (vecs[i]) run_vec(vecs[i]);
    p0 = pulses;
    bus.req_valid = 1'b1; bus.req_x = 32'd9; bus.req_y = 32'd3; bus.flush = 1'b1;
    #1 chk("flush_idle_ready", 32'(bus.req_ready), 32'd0);
    tick();
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    chk("flush_idle_busy", 32'(bus.busy), 32'd0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("cmpl_idle_busy", 32'(bus.busy), 32'd0);
    chk("cmpl_idle_valid", 32'(bus.res_valid), 32'd0);
    chk("flush_idle_pulses", 32'(pulses - p0), 32'd0);
    sb.push_back({32'hFFFF_FFFF, 32'd9, 5'd7, 1'b1});
    issue(32'd9, 32'd0, 1'b0, 5'd7, w);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("cmpl_done_valid", 32'(bus.res_valid), 32'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    issue(32'd5, 32'd0, 1'b0, 5'd8, w);
    bus.flush = 1'b1; bus.res_ready = 1'b1;
    tick();
    bus.flush = 1'b0; bus.res_ready = 1'b0;
    chk("flush_done_valid", 32'(bus.res_valid), 32'd0);
    chk("flush_done_busy", 32'(bus.busy), 32'd0);
    issue(32'd100, 32'd7, 1'b0, 5'd9, w);
    for (int i = 0; i < 9; i++) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("drain_busy", 32'(bus.busy), 32'd1);
    chk("drain_req_ready", 32'(bus.req_ready), 32'd0);
    n = 0;
    while (bus.busy && n < 60) begin
      chk("drain_res_valid", 32'(bus.res_valid), 32'd0);
      tick(); n++;
    end
    chk("drain_exit", 32'(bus.busy), 32'd0);
    run_vec(vecs[4]);
    issue(32'd100, 32'd7, 1'b0, 5'd10, w);
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_dv_x", bus.dv_x, 32'd0);
    chk("mid_rst_dv_y", bus.dv_y, 32'd0);
    chk("mid_rst_res_tag", 32'(bus.res_tag), 32'd0);
    #1 chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    wait_valid(n);
    chk("mid_rst_no_result", 32'(bus.res_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
